tdp_ram_ctrl: RTL
=================

TDP_RAM_CTRL -- requirements
Module: tdp_ram_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8; BYTES = DATA_WIDTH/8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 9: address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameters WRITE_MODE_A and WRITE_MODE_B, default "READ_FIRST": per-port write mode, one of "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
REQ-004 The block SHALL have parameters OUTPUT_REG_A and OUTPUT_REG_B, default "FALSE": "TRUE" adds one output pipeline stage on that port.
REQ-005 The block SHALL have parameter CLEAR_VALUE, default 0: DATA_WIDTH-bit word written by the clear engine.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port clr_req, input, 1 bit: single-cycle request to clear the whole array.
REQ-009 The block SHALL have port busy, output, 1 bit: clear in progress; user accesses are ignored while it is high.
REQ-010 Port A SHALL have: ena, input, 1 bit (access enable); wea, input, 1 bit (write); bea, input, BYTES bits (byte enables); addra, input, ADDR_WIDTH bits; dina, input, DATA_WIDTH bits; douta, output, DATA_WIDTH bits; douta_valid, output, 1 bit.
REQ-011 Port B SHALL have enb, web, beb, addrb, dinb, doutb and doutb_valid, identical to the port A signals of REQ-010.
REQ-012 The block SHALL have port coll, output, 1 bit: address-collision pulse.
REQ-013 The block SHALL have port coll_addr, output, ADDR_WIDTH bits: address of the last collision.

Function
REQ-014 The FSM SHALL have states CLEAR and READY; it SHALL enter CLEAR on reset release and on clr_req=1 while in READY.
REQ-015 In CLEAR, the block SHALL write CLEAR_VALUE to one address per cycle, from 0 up to DEPTH-1, then go to READY; busy SHALL fall in the cycle after address DEPTH-1 is written (DEPTH cycles in total).
REQ-016 The block SHALL ignore clr_req while in CLEAR; a clear is never restarted or extended.
REQ-017 While busy=1, the block SHALL drop ena/enb, perform no user writes, and hold douta_valid and doutb_valid at 0.
REQ-018 A read (en=1, we=0) SHALL produce data on dout, with dout_valid=1, 1 cycle later when OUTPUT_REG="FALSE" and 2 cycles later when OUTPUT_REG="TRUE"; dout SHALL hold its value between valid pulses.
REQ-019 A write (en=1, we=1) SHALL update only the bytes whose byte-enable bit is 1.
REQ-020 For a write, the output SHALL depend on the write mode: WRITE_FIRST returns the merged new word (new enabled bytes, old other bytes) with valid=1; READ_FIRST returns the old word with valid=1; NO_CHANGE leaves dout unchanged with valid=0.
REQ-021 When both ports write the same address in the same cycle, port B SHALL win on overlapping enabled bytes; non-overlapping bytes SHALL take the value from their own port.
REQ-022 When one port reads an address that the other port writes in the same cycle, the reading port SHALL return the old word.
REQ-023 A collision SHALL be defined as ena=enb=1, addra=addrb, busy=0, and (wea|web)=1.

Reset
REQ-024 While rst_n=0, the block SHALL drive douta=0, doutb=0, douta_valid=0, doutb_valid=0, coll=0, coll_addr=0 and busy=1, and hold the FSM in CLEAR with the clear address at 0.
REQ-025 Array contents SHALL NOT be reset; the clear engine starts on the first clk edge after rst_n rises.
REQ-026 Asserting rst_n mid-clear or mid-access SHALL abort the operation; a full clear SHALL restart from address 0 after release.

Configuration
REQ-027 With macro TDP_RAM_COLLISION_DETECT_EN defined, the block SHALL pulse coll for 1 cycle, one cycle after each collision, and load coll_addr with the colliding address in that same cycle; coll_addr SHALL hold until the next collision.
REQ-028 Without TDP_RAM_COLLISION_DETECT_EN, coll and coll_addr SHALL be tied to 0 and the ports SHALL remain present; data behaviour (REQ-021, REQ-022) SHALL be unchanged.

Verification
REQ-029 The bench SHALL cover: release rst_n, hold ena=1 -> busy=1 for exactly 512 cycles (ADDR_WIDTH=9), douta_valid=0 throughout; then reading address 0x1FF returns 0x00000000.
REQ-030 The bench SHALL cover: write 0xAABBCCDD to 0x010 with bea=4'b1111, then write 0x11223344 with bea=4'b0101 -> a read of 0x010 returns 0xAA22CC44, with valid 1 cycle after the read (2 cycles with OUTPUT_REG_A="TRUE").
REQ-031 The bench SHALL cover: WRITE_MODE_A="NO_CHANGE", read 0x005 (value 0x1), then write 0x2 to 0x005 -> douta stays 0x1 and douta_valid=0 on the write response.
REQ-032 The bench SHALL cover: both ports write 0x020 in the same cycle, A=0x11111111 with bea=4'b1111, B=0x22222222 with beb=4'b0011 -> word becomes 0x11112222; with the macro defined, coll=1 one cycle later and coll_addr=0x020.
REQ-033 The bench SHALL cover: clr_req pulsed in READY, with port B writing during busy -> the write is ignored, every word reads CLEAR_VALUE afterwards, and a second clr_req mid-clear does not extend busy.
REQ-034 The bench SHALL cover: rst_n asserted at clear address 100 -> busy stays 1, and after release the clear lasts a full 512 cycles.

Source files
------------

// File: rtl/tdp_ram_ctrl.sv
// True dual-port byte-enable RAM with a power-up/on-demand clear engine.
// Optional collision reporting on coll/coll_addr: define TDP_RAM_COLLISION_DETECT_EN.

module tdp_ram_port #(
    parameter int    DW         = 32,
    parameter string WRITE_MODE = "READ_FIRST",
    parameter string OUTPUT_REG = "FALSE"
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [DW-1:0] i_rdata,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_dout,
    output logic          o_valid
);
    localparam bit WF = (WRITE_MODE == "WRITE_FIRST");
    localparam bit NC = (WRITE_MODE == "NO_CHANGE");

    logic [DW-1:0] r_dout;
    logic          r_vld;
    logic          w_load;

    assign w_load = i_en && !(i_we && NC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= w_load;
            if (w_load) r_dout <= (i_we && WF) ? i_wdata : i_rdata;
        end
    end

    generate
        if (OUTPUT_REG == "TRUE") begin : g_oreg
            logic [DW-1:0] r_dout2;
            logic          r_vld2;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_dout2 <= '0;
                    r_vld2  <= 1'b0;
                end else begin
                    r_vld2 <= r_vld;
                    if (r_vld) r_dout2 <= r_dout;
                end
            end
            assign o_dout  = r_dout2;
            assign o_valid = r_vld2;
        end else begin : g_noreg
            assign o_dout  = r_dout;
            assign o_valid = r_vld;
        end
    endgenerate
endmodule

module tdp_ram_ctrl #(
    parameter int                       DATA_WIDTH   = 32,
    parameter int                       ADDR_WIDTH   = 9,
    parameter string                    WRITE_MODE_A = "READ_FIRST",
    parameter string                    WRITE_MODE_B = "READ_FIRST",
    parameter string                    OUTPUT_REG_A = "FALSE",
    parameter string                    OUTPUT_REG_B = "FALSE",
    parameter logic [DATA_WIDTH-1:0]    CLEAR_VALUE  = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_req,
    output logic                        busy,
    input  logic                        ena,
    input  logic                        wea,
    input  logic [DATA_WIDTH/8-1:0]     bea,
    input  logic [ADDR_WIDTH-1:0]       addra,
    input  logic [DATA_WIDTH-1:0]       dina,
    output logic [DATA_WIDTH-1:0]       douta,
    output logic                        douta_valid,
    input  logic                        enb,
    input  logic                        web,
    input  logic [DATA_WIDTH/8-1:0]     beb,
    input  logic [ADDR_WIDTH-1:0]       addrb,
    input  logic [DATA_WIDTH-1:0]       dinb,
    output logic [DATA_WIDTH-1:0]       doutb,
    output logic                        doutb_valid,
    output logic                        coll,
    output logic [ADDR_WIDTH-1:0]       coll_addr
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    w_ena, w_enb, w_wr_a, w_wr_b;
    logic [DATA_WIDTH-1:0]   w_rdata_a, w_rdata_b, w_wdata_a, w_wdata_b, w_wdata_b_eff;

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                     input logic [DATA_WIDTH-1:0] new_w,
                                                     input logic [BYTES-1:0]      be);
        logic [DATA_WIDTH-1:0] m;
        m = old_w;
        for (int b = 0; b < BYTES; b++)
            if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
        return m;
    endfunction

    assign busy   = (r_state == CLEAR);
    assign w_ena  = ena & ~busy;
    assign w_enb  = enb & ~busy;
    assign w_wr_a = w_ena & wea;
    assign w_wr_b = w_enb & web;

    assign w_rdata_a = r_mem[addra];
    assign w_rdata_b = r_mem[addrb];
    assign w_wdata_a = merge(w_rdata_a, dina, bea);
    assign w_wdata_b = merge(w_rdata_b, dinb, beb);
    // Same-address double write: B's enabled bytes land on top of A's merged word.
    assign w_wdata_b_eff = (w_wr_a && addra == addrb) ? merge(w_wdata_a, dinb, beb) : w_wdata_b;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (&r_clr_addr) w_state_nxt = READY;
            READY:   if (clr_req)     w_state_nxt = CLEAR;
            default: w_state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Counter wraps to 0 on the last clear write, ready for the next clear.
            if (r_state == CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_addr] <= CLEAR_VALUE;
        end else begin
            if (w_wr_a) r_mem[addra] <= w_wdata_a;
            if (w_wr_b) r_mem[addrb] <= w_wdata_b_eff;
        end
    end

    tdp_ram_port #(.DW(DATA_WIDTH), .WRITE_MODE(WRITE_MODE_A), .OUTPUT_REG(OUTPUT_REG_A)) u_port_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(w_ena), .i_we(wea),
        .i_rdata(w_rdata_a), .i_wdata(w_wdata_a), .o_dout(douta), .o_valid(douta_valid));

    tdp_ram_port #(.DW(DATA_WIDTH), .WRITE_MODE(WRITE_MODE_B), .OUTPUT_REG(OUTPUT_REG_B)) u_port_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(w_enb), .i_we(web),
        .i_rdata(w_rdata_b), .i_wdata(w_wdata_b), .o_dout(doutb), .o_valid(doutb_valid));

`ifdef TDP_RAM_COLLISION_DETECT_EN
    logic w_coll;
    logic r_coll;
    logic [ADDR_WIDTH-1:0] r_coll_addr;

    assign w_coll = w_ena & w_enb & (addra == addrb) & (wea | web);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll      <= 1'b0;
            r_coll_addr <= '0;
        end else begin
            r_coll <= w_coll;
            if (w_coll) r_coll_addr <= addra;
        end
    end

    assign coll      = r_coll;
    assign coll_addr = r_coll_addr;
`else
    assign coll      = 1'b0;
    assign coll_addr = '0;
`endif
endmodule
